// File: rtl/missile_control.sv
// Missile horizontal position register, copy scheduler and per-line fine motion.
// Issues a one-cycle strobe to the missile pixel generator at each copy's start pixel.
module missile_control #(
    parameter int SCREEN_WIDTH = 160,
    parameter int RESET_POS    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pixel_valid,
    input  logic [7:0] pixel_x,
    input  logic       line_start,
    input  logic       reg_write,
    input  logic [2:0] reg_addr,
    input  logic [7:0] reg_data,
    output logic       missile_strobe,
    output logic [1:0] missile_width,
    output logic       missile_enable,
    output logic [7:0] position
);

    localparam logic [2:0] ADDR_ENAM  = 3'd0;
    localparam logic [2:0] ADDR_NUSIZ = 3'd1;
    localparam logic [2:0] ADDR_RESM  = 3'd2;
    localparam logic [2:0] ADDR_HMM   = 3'd3;
    localparam logic [2:0] ADDR_HMOVE = 3'd4;
    localparam logic [2:0] ADDR_HMCLR = 3'd5;

    localparam logic signed [8:0] SW_S        = 9'(SCREEN_WIDTH);
    localparam logic [8:0]        SW_U        = 9'(SCREEN_WIDTH);
    localparam logic [7:0]        RESET_POS_8 = 8'(RESET_POS);

    logic [7:0]        pos_p0;
    logic signed [3:0] motion_p0;
    logic              enable_p0;
    logic [1:0]        width_p0;
    logic [2:0]        copies_p0;
    logic              hmove_armed;
    logic              strobe_p1;

    // Fold a signed position result back into 0..SCREEN_WIDTH-1.
    function automatic logic [7:0] wrap_pos(input logic signed [8:0] v);
        logic signed [8:0] r;
        r = v;
        if (v < 9'sd0)
            r = v + SW_S;
        else if (v >= SW_S)
            r = v - SW_S;
        return r[7:0];
    endfunction

    function automatic logic [7:0] copy_target(input logic [7:0] pos, input logic [6:0] off);
        logic [8:0] s;
        s = {1'b0, pos} + {2'b00, off};
        if (s >= SW_U)
            s = s - SW_U;
        return s[7:0];
    endfunction

    logic wr_enam, wr_nusiz, wr_resm, wr_hmm, wr_hmove, wr_hmclr;
    logic x_visible, has16, has32, has64, hit, apply_motion;
    logic signed [8:0] pos_s, motion_s;
    logic [7:0] moved_pos, resm_pos;
    logic unused_bits;

    assign unused_bits = reg_data[3];

    assign wr_enam  = reg_write && (reg_addr == ADDR_ENAM);
    assign wr_nusiz = reg_write && (reg_addr == ADDR_NUSIZ);
    assign wr_resm  = reg_write && (reg_addr == ADDR_RESM);
    assign wr_hmm   = reg_write && (reg_addr == ADDR_HMM);
    assign wr_hmove = reg_write && (reg_addr == ADDR_HMOVE);
    assign wr_hmclr = reg_write && (reg_addr == ADDR_HMCLR);

    assign x_visible = ({1'b0, pixel_x} < SW_U);
    assign resm_pos  = x_visible ? pixel_x : RESET_POS_8;

    always_comb begin
        has16 = (copies_p0 == 3'b001) || (copies_p0 == 3'b011);
        has32 = (copies_p0 == 3'b010) || (copies_p0 == 3'b011) || (copies_p0 == 3'b110);
        has64 = (copies_p0 == 3'b100) || (copies_p0 == 3'b110);
        hit   = (pixel_x == pos_p0)
             || (has16 && (pixel_x == copy_target(pos_p0, 7'd16)))
             || (has32 && (pixel_x == copy_target(pos_p0, 7'd32)))
             || (has64 && (pixel_x == copy_target(pos_p0, 7'd64)));
    end

    // A same-cycle HMOVE write defers the move to the next line.
    assign apply_motion = line_start && hmove_armed && !wr_hmove;
    assign pos_s        = $signed({1'b0, pos_p0});
    assign motion_s     = {{5{motion_p0[3]}}, motion_p0};
    assign moved_pos    = wrap_pos(pos_s - motion_s);

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_p0      <= 8'd0;
            motion_p0   <= 4'sd0;
            enable_p0   <= 1'b0;
            width_p0    <= 2'd0;
            copies_p0   <= 3'd0;
            hmove_armed <= 1'b0;
            strobe_p1   <= 1'b0;
        end else begin
            // Stage p1: compare uses the position/copies held before this cycle's writes.
            strobe_p1 <= pixel_valid && x_visible && hit;

            if (wr_resm)
                pos_p0 <= resm_pos;
            else if (apply_motion)
                pos_p0 <= moved_pos;

            if (wr_hmove)
                hmove_armed <= 1'b1;
            else if (apply_motion)
                hmove_armed <= 1'b0;

            if (wr_hmm)
                motion_p0 <= $signed(reg_data[7:4]);
            else if (wr_hmclr)
                motion_p0 <= 4'sd0;

            if (wr_enam)
                enable_p0 <= reg_data[1];

            if (wr_nusiz) begin
                width_p0  <= reg_data[5:4];
                copies_p0 <= reg_data[2:0];
            end
        end
    end

    assign missile_strobe = strobe_p1;
    assign missile_width  = width_p0;
    assign missile_enable = enable_p0;
    assign position       = pos_p0;

endmodule

// File: tb/tb_missile_control.sv
// Self-checking bench for missile_control: directed scenarios plus randomized
// traffic compared every cycle against a behavioural model of the register/copy rules.
module tb_missile_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pixel_valid = 1'b0;
    logic [7:0] pixel_x = 8'd0;
    logic       line_start = 1'b0;
    logic       reg_write = 1'b0;
    logic [2:0] reg_addr = 3'd0;
    logic [7:0] reg_data = 8'd0;
    logic       missile_strobe;
    logic [1:0] missile_width;
    logic       missile_enable;
    logic [7:0] position;

    missile_control #(.SCREEN_WIDTH(160), .RESET_POS(3)) dut (
        .clk(clk), .reset(reset), .pixel_valid(pixel_valid), .pixel_x(pixel_x),
        .line_start(line_start), .reg_write(reg_write), .reg_addr(reg_addr),
        .reg_data(reg_data), .missile_strobe(missile_strobe),
        .missile_width(missile_width), .missile_enable(missile_enable),
        .position(position)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Behavioural model state
    int       m_pos = 0;
    int       m_motion = 0;
    bit       m_en = 0;
    int       m_w = 0;
    int       m_cp = 0;
    bit       m_armed = 0;
    bit       m_strobe = 0;

    bit hits[0:159];
    int hit_count;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hit(input int px);
        int offs[4];
        bit [3:0] mask;
        bit h;
        offs = '{0, 16, 32, 64};
        case (m_cp)
            0: mask = 4'b0001;
            1: mask = 4'b0011;
            2: mask = 4'b0101;
            3: mask = 4'b0111;
            4: mask = 4'b1001;
            6: mask = 4'b1101;
            default: mask = 4'b0001;
        endcase
        h = 0;
        for (int k = 0; k < 4; k++)
            if (mask[k] && ((m_pos + offs[k]) % 160 == px)) h = 1;
        return h;
    endfunction

    task automatic model_tick();
        int np, nm;
        bit na, apply;
        logic signed [3:0] nib;
        if (reset) begin
            m_pos = 0; m_motion = 0; m_en = 0; m_w = 0; m_cp = 0; m_armed = 0; m_strobe = 0;
            return;
        end
        m_strobe = pixel_valid && (pixel_x < 160) && m_hit(int'(pixel_x));
        apply = line_start && m_armed && !(reg_write && reg_addr == 3'd4);
        np = m_pos;
        nm = m_motion;
        na = m_armed;
        if (apply) begin
            np = (((m_pos - m_motion) % 160) + 160) % 160;
            na = 0;
        end
        if (reg_write) begin
            case (reg_addr)
                3'd0: m_en = reg_data[1];
                3'd1: begin m_w = int'(reg_data[5:4]); m_cp = int'(reg_data[2:0]); end
                3'd2: np = (pixel_x < 160) ? int'(pixel_x) : 3;
                3'd3: begin nib = reg_data[7:4]; nm = nib; end
                3'd4: na = 1;
                3'd5: nm = 0;
                default: ;
            endcase
        end
        m_pos = np; m_motion = nm; m_armed = na;
    endtask

    task automatic compare();
        check("strobe", int'(missile_strobe), int'(m_strobe));
        check("width", int'(missile_width), m_w);
        check("enable", int'(missile_enable), int'(m_en));
        check("position", int'(position), m_pos);
    endtask

    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
        compare();
    endtask

    task automatic clear_inputs();
        reset = 0; pixel_valid = 0; line_start = 0; reg_write = 0;
        reg_addr = 0; reg_data = 0; pixel_x = 0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d, input logic [7:0] px);
        reg_write = 1; reg_addr = a; reg_data = d; pixel_x = px;
        step();
        reg_write = 0; reg_data = 0; reg_addr = 0;
    endtask

    task automatic sweep();
        hit_count = 0;
        for (int i = 0; i < 160; i++) hits[i] = 0;
        for (int px = 0; px < 160; px++) begin
            pixel_valid = 1; pixel_x = 8'(px);
            step();
            if (missile_strobe) begin hits[px] = 1; hit_count++; end
        end
        pixel_valid = 0;
        step();
    endtask

    task automatic pulse_line();
        line_start = 1;
        step();
        line_start = 0;
    endtask

    initial begin
        int rpx;
        // Reset state
        reset = 1;
        step(); step();
        check("reset_position", int'(position), 0);
        check("reset_strobe", int'(missile_strobe), 0);
        check("reset_width", int'(missile_width), 0);
        clear_inputs();
        step();

        // Single copy at 40
        wr(3'd1, 8'h00, 8'd0);
        wr(3'd2, 8'h00, 8'd40);
        check("resm40_position", int'(position), 40);
        sweep();
        check("single_count", hit_count, 1);
        check("single_at40", int'(hits[40]), 1);

        // Three copies from 150, width 2
        wr(3'd1, 8'h23, 8'd0);
        wr(3'd2, 8'h00, 8'd150);
        check("nusiz_width", int'(missile_width), 2);
        sweep();
        check("copies_count", hit_count, 3);
        check("copies_150", int'(hits[150]), 1);
        check("copies_6", int'(hits[6]), 1);
        check("copies_22", int'(hits[22]), 1);

        // +3 motion from 1 wraps to 158
        wr(3'd2, 8'h00, 8'd1);
        wr(3'd3, 8'h30, 8'd0);
        wr(3'd4, 8'h00, 8'd0);
        pulse_line();
        check("hmove_plus3", int'(position), 158);
        check("model_plus3", m_pos, 158);
        pulse_line();
        check("hmove_consumed", int'(position), 158);

        // -8 motion from 155 wraps to 3; then cleared motion leaves it
        wr(3'd2, 8'h00, 8'd155);
        wr(3'd3, 8'h80, 8'd0);
        wr(3'd4, 8'h00, 8'd0);
        pulse_line();
        check("hmove_minus8", int'(position), 3);
        check("model_minus8", m_pos, 3);
        wr(3'd5, 8'h00, 8'd0);
        wr(3'd4, 8'h00, 8'd0);
        pulse_line();
        check("hmclr_noop", int'(position), 3);

        // RESM in blank, then RESM coincident with a match at the old position
        wr(3'd1, 8'h00, 8'd0);
        wr(3'd2, 8'h00, 8'd200);
        check("resm_blank", int'(position), 3);
        wr(3'd2, 8'h00, 8'd40);
        pixel_valid = 1;
        wr(3'd2, 8'h00, 8'd40);
        pixel_valid = 0;
        check("resm_match_strobe", int'(missile_strobe), 1);

        // Reset coincident with a matching pixel drops the pending strobe
        wr(3'd0, 8'h02, 8'd0);
        wr(3'd1, 8'h36, 8'd0);
        wr(3'd3, 8'h50, 8'd0);
        wr(3'd4, 8'h00, 8'd0);
        wr(3'd2, 8'h00, 8'd40);
        check("pre_reset_enable", int'(missile_enable), 1);
        pixel_valid = 1; pixel_x = 8'd40; reset = 1;
        step();
        check("reset_drops_strobe", int'(missile_strobe), 0);
        check("reset_clears_pos", int'(position), 0);
        check("reset_clears_en", int'(missile_enable), 0);
        clear_inputs();
        step();
        check("reset_strobe_after", int'(missile_strobe), 0);
        pulse_line();
        check("reset_clears_armed", int'(position), 0);

        // Randomized traffic against the model
        rpx = 0;
        for (int n = 0; n < 6000; n++) begin
            pixel_x     = 8'(rpx);
            pixel_valid = ($urandom_range(0, 9) < 8);
            line_start  = (rpx == 0) || ($urandom_range(0, 99) == 0);
            reg_write   = ($urandom_range(0, 7) == 0);
            reg_addr    = 3'($urandom_range(0, 7));
            reg_data    = 8'($urandom_range(0, 255));
            reset       = ($urandom_range(0, 799) == 0);
            step();
            rpx = (rpx + 1) % 228;
        end
        clear_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
